// File: rtl/systolic_pipe.sv
// systolic_pipe: ROW x COLUMN systolic array of 1-bit cells with a valid/ready token pipeline.
// Ports:
//   clk, rst_n         clock and synchronous active-low reset
//   in_valid/in_ready  input handshake; in_ready is the global advance
//   inRow, inColumn    boundary bits feeding rows and columns of the array
//   out_valid/out_ready output handshake for the cell (ROW,COLUMN) result
//   out                result bit, forced to 0 while out_valid is low
//   busy               high while any accepted vector is still in flight
module systolic_pipe #(
    parameter int ROW    = 4,
    parameter int COLUMN = 9,
    parameter int MODE   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ROW-1:0]    inRow,
    input  logic [COLUMN-1:0] inColumn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out,
    output logic              busy
);
    localparam int L = ROW + COLUMN - 1;
    localparam int M = (MODE > 4 || MODE < 0) ? 0 : MODE;

    logic                   w_adv;
    logic                   w_acc;
    logic [L-1:0]           r_tok;
    logic [ROW:1]           w_rb;
    logic [COLUMN:1]        w_cb;
    logic [ROW:1][COLUMN:1] w_cell;

    function automatic logic f_op(input int i, input int j, input logic a, input logic b);
        return M == 1 ? a & b :
               M == 2 ? a | b :
               M == 3 ? a ^ b :
               M == 4 ? (i == j ? a & b : i < j ? a ^ b : a | b) :
               ~(a | b);
    endfunction

    // The whole pipe moves in lockstep: it advances whenever the output slot is free or being drained.
    assign w_adv     = out_ready | ~out_valid;
    assign w_acc     = in_valid & w_adv;
    assign in_ready  = w_adv;
    assign out_valid = r_tok[L-1];
    assign busy      = |r_tok;
    // Bubbles leave garbage in the data cells, so the result is masked by its token.
    assign out       = out_valid & w_cell[ROW][COLUMN];

    always_ff @(posedge clk)
        if (!rst_n)
            r_tok <= '0;
        else if (w_adv)
            r_tok <= L'({r_tok, w_acc});

    // Column j boundary is delayed j-1 stages so it meets the vector at cell (1,j).
    for (genvar j = 1; j <= COLUMN; j++) begin : g_col
        if (j == 1) begin : g_direct
            assign w_cb[j] = inColumn[0];
        end else begin : g_skew
            localparam int N = j - 1;
            logic [N-1:0] r_sk;
            always_ff @(posedge clk)
                if (!rst_n)
                    r_sk <= '0;
                else if (w_adv)
                    r_sk <= N'({r_sk, inColumn[j-1]});
            assign w_cb[j] = r_sk[N-1];
        end
    end

    for (genvar i = 1; i <= ROW; i++) begin : g_r
        // Row i boundary is delayed i-1 stages so it meets the vector at cell (i,1).
        if (i == 1) begin : g_direct
            assign w_rb[i] = inRow[0];
        end else begin : g_skew
            localparam int N = i - 1;
            logic [N-1:0] r_sk;
            always_ff @(posedge clk)
                if (!rst_n)
                    r_sk <= '0;
                else if (w_adv)
                    r_sk <= N'({r_sk, inRow[i-1]});
            assign w_rb[i] = r_sk[N-1];
        end
        for (genvar j = 1; j <= COLUMN; j++) begin : g_c
            logic w_l;
            logic w_u;
            logic r_q;
            if (j == 1) begin : g_lb
                assign w_l = w_rb[i];
            end else begin : g_li
                assign w_l = w_cell[i][j-1];
            end
            if (i == 1) begin : g_ub
                assign w_u = w_cb[j];
            end else begin : g_ui
                assign w_u = w_cell[i-1][j];
            end
            always_ff @(posedge clk)
                if (!rst_n)
                    r_q <= 1'b0;
                else if (w_adv)
                    r_q <= f_op(i, j, w_l, w_u);
            assign w_cell[i][j] = r_q;
        end
    end
endmodule

// File: doc/systolic_pipe.md
SYSTOLIC_PIPE -- requirements
Module: systolic_pipe

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ROW, 4, number of array rows; legal range 1..16.
- COLUMN, 9, number of array columns; legal range 1..16.
- MODE, 0, cell operator select:
  - 0 = NOR in every cell.
  - 1 = AND in every cell.
  - 2 = OR in every cell.
  - 3 = XOR in every cell.
  - 4 = diagonal mode: AND if i==j, XOR if i<j, OR if i>j.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, input, 1, sole clock; all state updates on the rising edge.
- rst_n, input, 1, reset; synchronous, active-low.
- in_valid, input, 1, input vector offered.
- in_ready, output, 1, block accepts the vector this cycle.
- inRow, input, ROW, row boundary bits; inRow[i-1] feeds row i.
- inColumn, input, COLUMN, column boundary bits; inColumn[j-1] feeds column j.
- out_valid, output, 1, out holds a result.
- out_ready, input, 1, consumer accepts out this cycle.
- out, output, 1, cell (ROW,COLUMN) result.
- busy, output, 1, one or more accepted vectors not yet consumed.

Function
REQ-003 Cell recurrence SHALL be w[i][j] = op(w[i][j-1], w[i-1][j]), with i in 1..ROW and j in 1..COLUMN.
REQ-004 Boundary values SHALL be w[i][0] = inRow[i-1] and w[0][j] = inColumn[j-1].
REQ-005 Each cell SHALL own one register; cell (i,j) SHALL sit at pipeline stage i+j-1.
REQ-006 The block SHALL delay inRow[i-1] by i-1 stages and inColumn[j-1] by j-1 stages, so that every cell sees operands from the same accepted vector.
REQ-007 Latency SHALL be L = ROW+COLUMN-1 cycles, counted from acceptance to out_valid, with no stalls in between (L = 12 for 4x9).
REQ-008 The block SHALL shift a valid token alongside the data through L stages; out_valid SHALL be the last stage's token.
REQ-009 The global advance signal SHALL be adv = out_ready | ~out_valid; all data, skew and token registers SHALL update only when adv=1.
REQ-010 in_ready SHALL equal adv combinationally; a vector SHALL be accepted when in_valid & in_ready.
REQ-011 A cycle with adv=1 and no accepted vector SHALL inject a bubble (token 0); data registers in that stage MAY take any value.
REQ-012 When adv=0, every register SHALL hold its value; out and out_valid SHALL remain stable until consumed.
REQ-013 Throughput SHALL be one vector per cycle while out_ready=1; the pipeline SHALL hold up to L vectors in flight.
REQ-014 busy SHALL be the OR of all token bits.
REQ-015 Simultaneous acceptance and consumption SHALL both take effect in the same cycle; the block SHALL lose no data and SHALL duplicate no data.
REQ-016 MODE SHALL be elaboration-time only; MODE values above 4 SHALL be treated as 0.
REQ-017 out SHALL be 0 whenever out_valid=0 after reset, until the first result arrives.

Reset
REQ-018 rst_n=0 at a rising edge SHALL clear all token bits, all data registers and all skew registers to 0.
REQ-019 During reset and on the first cycle after it:
- out_valid = 0, out = 0, busy = 0;
- in_ready = 1 (follows from REQ-009 with out_valid = 0).
REQ-020 Reset asserted mid-operation SHALL discard all in-flight vectors; no stale result SHALL appear after reset is released.

Verification
REQ-021 ROW=4, COLUMN=9, MODE=0; one vector inRow=4'h0, inColumn=9'h1FF; out_ready=1 -> out_valid=1 with out=1 exactly 12 cycles after acceptance, then out_valid=0.
REQ-022 Same configuration, vector inRow=4'hF, inColumn=9'h1FF -> out=0 after 12 cycles; inRow=4'h0, inColumn=9'h000 -> out=0.
REQ-023 Stream 20 random vectors back-to-back with out_ready=1 -> 20 results in order, one per cycle, each matching the bench golden model for every MODE 0..4.
REQ-024 Random in_valid and out_ready toggling (50%) over 500 vectors -> no loss, no duplication, order preserved; out stable while out_valid & ~out_ready.
REQ-025 Accept 5 vectors, then pulse rst_n=0 for 1 cycle -> out_valid=0 and busy=0 from the next cycle; no result emitted until a new vector has been accepted and 12 cycles have elapsed.
REQ-026 Corner configurations ROW=1, COLUMN=1 (L=1) and ROW=16, COLUMN=16 (L=31) -> latency equals ROW+COLUMN-1, and results match the golden model.
